surf_id_ctrl: RTL

WISHBONE classic slave giving the SURF's identification, scratch, control and status registers. It is the responder that the serial board-manager master and the TURF command master reach through the 22-bit register space. It replaces the combinational ident/version stub with a registered-ack slave. It adds byte-lane writes, pulse generation, sticky status capture and an optional uptime counter.

---
 rtl/surf_id_ctrl.sv | 136 +++++++++++++
 1 files changed

// File: rtl/surf_id_ctrl.sv
// WISHBONE classic register slave for SURF identification, scratch, control, pulse and status.
// Optional free-running UPTIME counter at 0x18 when SURF_ID_CTRL_UPTIME_EN is defined.
module surf_id_ctrl #(
    parameter logic [31:0] IDENT       = 32'h5355_5246,
    parameter logic [31:0] DATEVERSION = 32'h0,
    parameter logic [31:0] CTRL_RESET  = 32'h0
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [21:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    input  logic [31:0] status_i,
    output logic [31:0] ctrl_o,
    output logic [31:0] pulse_o
);

    typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_t;

    typedef enum logic [2:0] {
        REG_IDENT   = 3'd0,
        REG_DATEVER = 3'd1,
        REG_SCRATCH = 3'd2,
        REG_CTRL    = 3'd3,
        REG_PULSE   = 3'd4,
        REG_STATUS  = 3'd5,
        REG_UPTIME  = 3'd6,
        REG_STICKY  = 3'd7
    } reg_t;

    state_t      state_q, state_d;
    logic        access;
    logic        mapped;
    logic        wr_en;
    reg_t        reg_sel;
    logic [31:0] lane_mask;
    logic [31:0] rdata;
    logic [31:0] scratch_q;
    logic [31:0] sticky_q;
    logic [31:0] status_q;
    logic [31:0] status_d;
    logic [31:0] uptime_val;
    logic        unused_adr_lsbs;

    // Byte offset bits never take part in decode.
    assign unused_adr_lsbs = ^wb_adr_i[1:0];

    assign mapped    = (wb_adr_i[21:5] == 17'd0);
    assign reg_sel   = reg_t'(wb_adr_i[4:2]);
    assign wr_en     = access & mapped & wb_we_i;
    assign lane_mask = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}}, {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        access  = 1'b0;
        case (state_q)
            IDLE: begin
                if (wb_cyc_i && wb_stb_i) begin
                    access  = 1'b1;
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rdata = 32'h0;
        case (reg_sel)
            REG_IDENT:   rdata = IDENT;
            REG_DATEVER: rdata = DATEVERSION;
            REG_SCRATCH: rdata = scratch_q;
            REG_CTRL:    rdata = ctrl_o;
            REG_PULSE:   rdata = 32'h0;
            REG_STATUS:  rdata = status_q;
            REG_UPTIME:  rdata = uptime_val;
            REG_STICKY:  rdata = sticky_q;
            default:     rdata = 32'h0;
        endcase
    end

    // NOTE: non-blocking assignments make wb_dat_o capture the value from before this edge's write.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q   <= IDLE;
            wb_ack_o  <= 1'b0;
            wb_err_o  <= 1'b0;
            wb_dat_o  <= 32'h0;
            ctrl_o    <= CTRL_RESET;
            pulse_o   <= 32'h0;
            scratch_q <= 32'h0;
            sticky_q  <= 32'h0;
            status_q  <= 32'h0;
            status_d  <= 32'h0;
        end else begin
            state_q  <= state_d;
            wb_ack_o <= access & mapped;
            wb_err_o <= access & ~mapped;
            wb_dat_o <= (access && mapped && !wb_we_i) ? rdata : 32'h0;
            pulse_o  <= (wr_en && reg_sel == REG_PULSE) ? (wb_dat_i & lane_mask) : 32'h0;
            if (wr_en && reg_sel == REG_SCRATCH)
                scratch_q <= (scratch_q & ~lane_mask) | (wb_dat_i & lane_mask);
            if (wr_en && reg_sel == REG_CTRL)
                ctrl_o <= (ctrl_o & ~lane_mask) | (wb_dat_i & lane_mask);
            // New rising edges are OR'd in after the clear, so a set beats a same-cycle W1C.
            if (wr_en && reg_sel == REG_STICKY)
                sticky_q <= (sticky_q & ~(wb_dat_i & lane_mask)) | (status_q & ~status_d);
            else
                sticky_q <= sticky_q | (status_q & ~status_d);
            status_q <= status_i;
            status_d <= status_q;
        end
    end

`ifdef SURF_ID_CTRL_UPTIME_EN
    logic [31:0] uptime_q;

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) uptime_q <= 32'h0;
        else             uptime_q <= uptime_q + 32'd1;
    end

    assign uptime_val = uptime_q;
`else
    assign uptime_val = 32'h0;
`endif

endmodule
